// File: rtl/uart_pkg.sv
// -----------------------------------------------------------------------------
// uart_pkg
// Shared types and constants for the UART receive path.
//   uart_rx_state_t   : receiver FSM states
//   UART_PAR_EVEN/ODD : values for the PARITY_ODD parameter
//   *_MIN / *_MAX     : legal ranges for DATA_BITS and OVERSAMPLE
//   majority3()       : 2-of-3 vote used at the bit centre
// -----------------------------------------------------------------------------
package uart_pkg;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP,
        BRK_WAIT
    } uart_rx_state_t;

    localparam int UART_PAR_EVEN = 0;
    localparam int UART_PAR_ODD  = 1;

    localparam int UART_DATA_BITS_MIN  = 5;
    localparam int UART_DATA_BITS_MAX  = 9;
    localparam int UART_OVERSAMPLE_MIN = 8;
    localparam int UART_OVERSAMPLE_MAX = 32;

    function automatic logic majority3(input logic a, input logic b, input logic c);
        return (a & b) | (a & c) | (b & c);
    endfunction

endpackage

// File: rtl/uart_rx_sampler.sv
// -----------------------------------------------------------------------------
// uart_rx_sampler
// Front end of the receiver: 2-flop synchroniser, per-bit tick counter and
// 3-sample majority voter around the bit centre.
//   baud_clk  in  : OVERSAMPLE x baud sampling clock
//   reset     in  : synchronous, active-high
//   data_tx   in  : asynchronous serial line, idle high
//   tick_clr  in  : hold/return the tick counter to 0 (FSM idle or leaving)
//   line      out : synchronised serial line
//   bit_val   out : majority of line at ticks MID-1, MID, MID+1
//   decide    out : decision cycle (tick == MID+1), bit_val is valid
//   bit_end   out : last tick of the bit period (tick == OVERSAMPLE-1)
// -----------------------------------------------------------------------------
module uart_rx_sampler
    import uart_pkg::*;
#(
    parameter int OVERSAMPLE = 16
) (
    input  logic baud_clk,
    input  logic reset,
    input  logic data_tx,
    input  logic tick_clr,
    output logic line,
    output logic bit_val,
    output logic decide,
    output logic bit_end
);

    localparam int TICK_W = $clog2(OVERSAMPLE);
    localparam int MID    = OVERSAMPLE / 2;

    localparam logic [TICK_W-1:0] TICK_PRE  = TICK_W'(MID - 1);
    localparam logic [TICK_W-1:0] TICK_MID  = TICK_W'(MID);
    localparam logic [TICK_W-1:0] TICK_DEC  = TICK_W'(MID + 1);
    localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(OVERSAMPLE - 1);

    logic [1:0]        sync_q;
    logic [TICK_W-1:0] tick_q;
    logic              samp_pre_q;
    logic              samp_mid_q;

    // NOTE: clocked state is written only with non-blocking assignments so
    // every flop samples the pre-edge value of the others, independent of
    // statement order or process scheduling.
    always_ff @(posedge baud_clk) begin
        if (reset) begin
            sync_q     <= 2'b11;
            tick_q     <= '0;
            samp_pre_q <= 1'b1;
            samp_mid_q <= 1'b1;
        end else begin
            sync_q <= {sync_q[0], data_tx};
            if (tick_clr || tick_q == TICK_LAST) begin
                tick_q <= '0;
            end else begin
                tick_q <= tick_q + TICK_W'(1);
            end
            // The third vote is the live line value in the decision cycle.
            if (tick_q == TICK_PRE) samp_pre_q <= line;
            if (tick_q == TICK_MID) samp_mid_q <= line;
        end
    end

    assign line    = sync_q[1];
    assign bit_val = majority3(samp_pre_q, samp_mid_q, line);
    assign decide  = (tick_q == TICK_DEC);
    assign bit_end = (tick_q == TICK_LAST);

endmodule

// File: rtl/uart_rx_deserializer.sv
// -----------------------------------------------------------------------------
// uart_rx_deserializer
// Parametrised UART receiver: deframes start/data/parity/stop, detects
// false starts, parity and framing errors, breaks and overruns, and presents
// each word through a valid/ready handshake.
//   baud_clk    in  : OVERSAMPLE x baud sampling clock
//   reset       in  : synchronous, active-high
//   data_tx     in  : asynchronous serial line, idle high
//   rx_data     out : received word (LSB first on the wire)
//   rx_valid    out : word and status available
//   rx_ready    in  : consumer accepts the word
//   parity_err  out : parity mismatch in the held word
//   frame_err   out : a stop bit was sampled low
//   break_det   out : the held word is a break condition
//   overrun     out : frame(s) dropped while rx_valid was held
//   active_flag out : a frame is in progress (state != IDLE)
// -----------------------------------------------------------------------------
module uart_rx_deserializer
    import uart_pkg::*;
#(
    parameter int DATA_BITS  = 8,
    parameter int OVERSAMPLE = 16,
    parameter int PARITY_EN  = 1,
    parameter int PARITY_ODD = UART_PAR_EVEN,
    parameter int STOP_BITS  = 1
) (
    input  logic                 baud_clk,
    input  logic                 reset,
    input  logic                 data_tx,
    output logic [DATA_BITS-1:0] rx_data,
    output logic                 rx_valid,
    input  logic                 rx_ready,
    output logic                 parity_err,
    output logic                 frame_err,
    output logic                 break_det,
    output logic                 overrun,
    output logic                 active_flag
);

    if (DATA_BITS < UART_DATA_BITS_MIN || DATA_BITS > UART_DATA_BITS_MAX) begin : g_bad_data_bits
        $fatal(1, "uart_rx_deserializer: DATA_BITS=%0d out of range", DATA_BITS);
    end
    if (OVERSAMPLE < UART_OVERSAMPLE_MIN || OVERSAMPLE > UART_OVERSAMPLE_MAX
        || (OVERSAMPLE % 2) != 0) begin : g_bad_oversample
        $fatal(1, "uart_rx_deserializer: OVERSAMPLE=%0d illegal", OVERSAMPLE);
    end
    if (PARITY_EN != 0 && PARITY_EN != 1) begin : g_bad_parity_en
        $fatal(1, "uart_rx_deserializer: PARITY_EN=%0d illegal", PARITY_EN);
    end
    if (PARITY_ODD != UART_PAR_EVEN && PARITY_ODD != UART_PAR_ODD) begin : g_bad_parity_odd
        $fatal(1, "uart_rx_deserializer: PARITY_ODD=%0d illegal", PARITY_ODD);
    end
    if (STOP_BITS != 1 && STOP_BITS != 2) begin : g_bad_stop_bits
        $fatal(1, "uart_rx_deserializer: STOP_BITS=%0d illegal", STOP_BITS);
    end

    localparam int                CNT_W     = $clog2(DATA_BITS);
    localparam logic [CNT_W-1:0]  LAST_BIT  = CNT_W'(DATA_BITS - 1);
    localparam logic              LAST_STOP = 1'(STOP_BITS - 1);
    localparam logic              PAR_INV   = (PARITY_ODD == UART_PAR_ODD);

    uart_rx_state_t       state_q;
    uart_rx_state_t       state_d;
    logic [DATA_BITS-1:0] shift_q;
    logic [CNT_W-1:0]     bit_cnt_q;
    logic                 stop_cnt_q;
    logic                 par_err_q;
    logic                 frm_err_q;
    logic                 par_bit_q;

    logic line;
    logic bit_val;
    logic decide;
    logic bit_end;
    logic tick_clr;
    logic complete;
    logic frame_fe;
    logic frame_brk;
    logic par_expect;
    logic accept;

    // Clearing on the way into IDLE as well keeps tick at 0 for the whole
    // IDLE stay, so the first START cycle is always tick 0.
    assign tick_clr = (state_q == IDLE) || (state_d == IDLE);

    uart_rx_sampler #(
        .OVERSAMPLE (OVERSAMPLE)
    ) u_sampler (
        .baud_clk (baud_clk),
        .reset    (reset),
        .data_tx  (data_tx),
        .tick_clr (tick_clr),
        .line     (line),
        .bit_val  (bit_val),
        .decide   (decide),
        .bit_end  (bit_end)
    );

    // The frame ends in the decision cycle of the last stop bit, not at its
    // wrap, leaving half a bit of margin to resync on a following start bit.
    assign complete   = (state_q == STOP) && decide && (stop_cnt_q == LAST_STOP);
    assign frame_fe   = frm_err_q | ~bit_val;
    assign frame_brk  = (shift_q == '0) && (PARITY_EN == 0 || !par_bit_q) && !bit_val;
    assign par_expect = (^shift_q) ^ PAR_INV;
    assign accept     = !rx_valid || rx_ready;

    // NOTE: state_d gets its default before the case so every path assigns
    // it; a missing branch would otherwise infer a latch.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:     if (!line) state_d = START;
            START: begin
                if (decide && bit_val) begin
                    state_d = IDLE;
                end else if (bit_end) begin
                    state_d = DATA;
                end
            end
            DATA: begin
                if (bit_end && bit_cnt_q == LAST_BIT) begin
                    state_d = (PARITY_EN != 0) ? PARITY : STOP;
                end
            end
            PARITY:   if (bit_end) state_d = STOP;
            STOP:     if (complete) state_d = frame_brk ? BRK_WAIT : IDLE;
            BRK_WAIT: if (line) state_d = IDLE;
            default:  state_d = IDLE;
        endcase
    end

    always_ff @(posedge baud_clk) begin
        if (reset) begin
            state_q    <= IDLE;
            bit_cnt_q  <= '0;
            stop_cnt_q <= 1'b0;
            par_err_q  <= 1'b0;
            frm_err_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            case (state_q)
                IDLE: begin
                    bit_cnt_q  <= '0;
                    stop_cnt_q <= 1'b0;
                    par_err_q  <= 1'b0;
                    frm_err_q  <= 1'b0;
                end
                DATA: begin
                    if (bit_end) begin
                        bit_cnt_q <= (bit_cnt_q == LAST_BIT) ? '0 : bit_cnt_q + CNT_W'(1);
                    end
                end
                PARITY: begin
                    if (decide && bit_val != par_expect) par_err_q <= 1'b1;
                end
                STOP: begin
                    if (decide && !bit_val) frm_err_q <= 1'b1;
                    if (bit_end) stop_cnt_q <= 1'b1;
                end
                default: ;
            endcase
        end
    end

    // NOTE: the shift register and captured parity bit carry no reset; every
    // frame rewrites them completely before they are read at completion.
    always_ff @(posedge baud_clk) begin
        if (state_q == DATA && decide) shift_q <= {bit_val, shift_q[DATA_BITS-1:1]};
        if (state_q == PARITY && decide) par_bit_q <= bit_val;
    end

    always_ff @(posedge baud_clk) begin
        if (reset) begin
            rx_data    <= '0;
            rx_valid   <= 1'b0;
            parity_err <= 1'b0;
            frame_err  <= 1'b0;
            break_det  <= 1'b0;
            overrun    <= 1'b0;
        end else if (complete) begin
            if (accept) begin
                rx_data    <= shift_q;
                rx_valid   <= 1'b1;
                parity_err <= (PARITY_EN != 0) && par_err_q;
                frame_err  <= frame_fe;
                break_det  <= frame_brk;
                overrun    <= 1'b0;
            end else begin
                // Held word stays untouched; only the drop is recorded.
                overrun <= 1'b1;
            end
        end else if (rx_valid && rx_ready) begin
            rx_valid <= 1'b0;
            overrun  <= 1'b0;
        end
    end

    assign active_flag = (state_q != IDLE);

endmodule

// File: tb/tb_uart_rx_deserializer.sv
// -----------------------------------------------------------------------------
// tb_uart_rx_deserializer
// Directed bench. DUT a: 8 data bits, even parity, 1 stop, 16x oversampling.
// DUT b: 9 data bits, odd parity, 2 stops, 8x oversampling.
// Inputs change on the falling edge; outputs are sampled on the falling edge.
// Line driven low at falling edge N0 reaches the FSM two cycles later, so for
// DUT a a frame's rx_valid is first visible at falling edge N0+173.
// -----------------------------------------------------------------------------
module tb_uart_rx_deserializer;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       reset;
    logic       data_tx_a;
    logic       rx_ready_a;
    logic [7:0] rx_data_a;
    logic       rx_valid_a, parity_err_a, frame_err_a, break_det_a, overrun_a, active_flag_a;

    logic       data_tx_b;
    logic       rx_ready_b;
    logic [8:0] rx_data_b;
    logic       rx_valid_b, parity_err_b, frame_err_b, break_det_b, overrun_b, active_flag_b;

    int checks = 0;
    int errors = 0;

    uart_rx_deserializer #(
        .DATA_BITS(8), .OVERSAMPLE(16), .PARITY_EN(1), .PARITY_ODD(0), .STOP_BITS(1)
    ) dut_a (
        .baud_clk    (clk),
        .reset       (reset),
        .data_tx     (data_tx_a),
        .rx_data     (rx_data_a),
        .rx_valid    (rx_valid_a),
        .rx_ready    (rx_ready_a),
        .parity_err  (parity_err_a),
        .frame_err   (frame_err_a),
        .break_det   (break_det_a),
        .overrun     (overrun_a),
        .active_flag (active_flag_a)
    );

    uart_rx_deserializer #(
        .DATA_BITS(9), .OVERSAMPLE(8), .PARITY_EN(1), .PARITY_ODD(1), .STOP_BITS(2)
    ) dut_b (
        .baud_clk    (clk),
        .reset       (reset),
        .data_tx     (data_tx_b),
        .rx_data     (rx_data_b),
        .rx_valid    (rx_valid_b),
        .rx_ready    (rx_ready_b),
        .parity_err  (parity_err_b),
        .frame_err   (frame_err_b),
        .break_det   (break_det_b),
        .overrun     (overrun_b),
        .active_flag (active_flag_b)
    );

    // {valid, data, parity_err, frame_err, break_det, overrun}
    function automatic logic [12:0] obs_a();
        return {rx_valid_a, rx_data_a, parity_err_a, frame_err_a, break_det_a, overrun_a};
    endfunction

    function automatic logic [13:0] obs_b();
        return {rx_valid_b, rx_data_b, parity_err_b, frame_err_b, break_det_b, overrun_b};
    endfunction

    // Frame bits LSB first: start, data, parity, stop(s).
    function automatic logic [15:0] frm_a(input logic [7:0] d, input logic par, input logic stp);
        return {5'b0, stp, par, d, 1'b0};
    endfunction

    function automatic logic [15:0] frm_b(input logic [8:0] d, input logic par);
        return {3'b0, 2'b11, par, d, 1'b0};
    endfunction

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Drives up to 'stop_after' cycles of an 11-bit frame; cycle 'glitch' is inverted.
    task automatic send_a(input logic [15:0] frame, input int glitch, input int stop_after);
        for (int k = 0; k < 11 * 16 && k < stop_after; k++) begin
            data_tx_a = frame[k / 16] ^ (k == glitch);
            @(negedge clk);
        end
        data_tx_a = 1'b1;
    endtask

    task automatic send_b(input logic [15:0] frame);
        for (int k = 0; k < 13 * 8; k++) begin
            data_tx_b = frame[k / 8];
            @(negedge clk);
        end
        data_tx_b = 1'b1;
    endtask

    task automatic test_reset();
        reset      = 1'b1;
        data_tx_a  = 1'b1;
        data_tx_b  = 1'b1;
        rx_ready_a = 1'b0;
        rx_ready_b = 1'b0;
        idle(3);
        checks++;
        if ({obs_a(), active_flag_a} !== 14'h0) begin
            errors++;
            $display("FAIL reset_a: got %h expected %h", {obs_a(), active_flag_a}, 14'h0);
        end
        checks++;
        if ({obs_b(), active_flag_b} !== 15'h0) begin
            errors++;
            $display("FAIL reset_b: got %h expected %h", {obs_b(), active_flag_b}, 15'h0);
        end
        reset = 1'b0;
        idle(4);
        checks++;
        if ({obs_a(), active_flag_a} !== 14'h0) begin
            errors++;
            $display("FAIL idle_after_reset: got %h expected %h", {obs_a(), active_flag_a}, 14'h0);
        end
    endtask

    task automatic test_clean();
        rx_ready_a = 1'b1;
        fork
            send_a(frm_a(8'hA5, 1'b0, 1'b1), -1, 1000);
            begin
                repeat (172) @(negedge clk);
                checks++;
                if (rx_valid_a !== 1'b0) begin
                    errors++;
                    $display("FAIL clean_early: got valid=%b expected 0", rx_valid_a);
                end
                @(negedge clk);
                checks++;
                if (obs_a() !== {1'b1, 8'hA5, 4'b0000}) begin
                    errors++;
                    $display("FAIL clean_word: got %h expected %h", obs_a(), {1'b1, 8'hA5, 4'b0000});
                end
                @(negedge clk);
                checks++;
                if (rx_valid_a !== 1'b0) begin
                    errors++;
                    $display("FAIL clean_pulse: got valid=%b expected 0", rx_valid_a);
                end
            end
        join
        idle(4);
    endtask

    task automatic test_errors();
        rx_ready_a = 1'b0;
        send_a(frm_a(8'h3C, 1'b1, 1'b1), -1, 1000);
        idle(2);
        checks++;
        if (obs_a() !== {1'b1, 8'h3C, 4'b1000}) begin
            errors++;
            $display("FAIL parity_word: got %h expected %h", obs_a(), {1'b1, 8'h3C, 4'b1000});
        end
        rx_ready_a = 1'b1;
        @(negedge clk);
        rx_ready_a = 1'b0;
        checks++;
        if (rx_valid_a !== 1'b0) begin
            errors++;
            $display("FAIL parity_handshake: got valid=%b expected 0", rx_valid_a);
        end
        // Low stop bit with non-zero data: framing error but not a break.
        send_a(frm_a(8'h81, 1'b0, 1'b0), -1, 1000);
        idle(20);
        checks++;
        if ({obs_a(), active_flag_a} !== {1'b1, 8'h81, 4'b0100, 1'b0}) begin
            errors++;
            $display("FAIL frame_word: got %h expected %h", {obs_a(), active_flag_a},
                     {1'b1, 8'h81, 4'b0100, 1'b0});
        end
        rx_ready_a = 1'b1;
        @(negedge clk);
        rx_ready_a = 1'b0;
    endtask

    task automatic test_noise();
        int nvalid;
        // 4-cycle low pulse: START entered, then rejected at the decision cycle.
        rx_ready_a = 1'b1;
        data_tx_a  = 1'b0;
        idle(3);
        checks++;
        if (active_flag_a !== 1'b1) begin
            errors++;
            $display("FAIL noise_start: got active=%b expected 1", active_flag_a);
        end
        @(negedge clk);
        data_tx_a = 1'b1;
        idle(8);
        checks++;
        if (active_flag_a !== 1'b1) begin
            errors++;
            $display("FAIL noise_decide: got active=%b expected 1", active_flag_a);
        end
        @(negedge clk);
        checks++;
        if (active_flag_a !== 1'b0) begin
            errors++;
            $display("FAIL noise_reject: got active=%b expected 0", active_flag_a);
        end
        // 9-cycle low (MID+1) is still a false start.
        idle(10);
        data_tx_a = 1'b0;
        idle(9);
        data_tx_a = 1'b1;
        nvalid = 0;
        for (int i = 0; i < 220; i++) begin
            @(negedge clk);
            if (rx_valid_a) nvalid++;
        end
        checks++;
        if (nvalid !== 0) begin
            errors++;
            $display("FAIL noise_short_start: got %0d words expected 0", nvalid);
        end
        // 10-cycle low (MID+2) is a valid start; all-ones rest gives 0xFF with a bad parity bit.
        rx_ready_a = 1'b0;
        data_tx_a  = 1'b0;
        idle(10);
        data_tx_a = 1'b1;
        idle(200);
        checks++;
        if (obs_a() !== {1'b1, 8'hFF, 4'b1000}) begin
            errors++;
            $display("FAIL noise_min_start: got %h expected %h", obs_a(), {1'b1, 8'hFF, 4'b1000});
        end
        rx_ready_a = 1'b1;
        @(negedge clk);
        rx_ready_a = 1'b0;
        // High glitch exactly on the centre sample of data bit 3 is outvoted.
        send_a(frm_a(8'h00, 1'b0, 1'b1), 73, 1000);
        idle(2);
        checks++;
        if (obs_a() !== {1'b1, 8'h00, 4'b0000}) begin
            errors++;
            $display("FAIL noise_glitch: got %h expected %h", obs_a(), {1'b1, 8'h00, 4'b0000});
        end
        rx_ready_a = 1'b1;
        @(negedge clk);
        rx_ready_a = 1'b0;
    endtask

    task automatic test_overrun();
        rx_ready_a = 1'b0;
        send_a(frm_a(8'h11, 1'b0, 1'b1), -1, 1000);
        send_a(frm_a(8'h22, 1'b0, 1'b1), -1, 1000);
        idle(2);
        checks++;
        if (obs_a() !== {1'b1, 8'h11, 4'b0001}) begin
            errors++;
            $display("FAIL overrun_hold: got %h expected %h", obs_a(), {1'b1, 8'h11, 4'b0001});
        end
        rx_ready_a = 1'b1;
        @(negedge clk);
        rx_ready_a = 1'b0;
        checks++;
        if ({rx_valid_a, overrun_a} !== 2'b00) begin
            errors++;
            $display("FAIL overrun_clear: got %b expected 00", {rx_valid_a, overrun_a});
        end
        send_a(frm_a(8'h33, 1'b0, 1'b1), -1, 1000);
        send_a(frm_a(8'h44, 1'b0, 1'b1), -1, 1000);
        checks++;
        if (obs_a() !== {1'b1, 8'h33, 4'b0001}) begin
            errors++;
            $display("FAIL overrun_second: got %h expected %h", obs_a(), {1'b1, 8'h33, 4'b0001});
        end
        // Handshake lands exactly in the completion cycle of 0x55.
        fork
            send_a(frm_a(8'h55, 1'b0, 1'b1), -1, 1000);
            begin
                repeat (172) @(negedge clk);
                rx_ready_a = 1'b1;
                @(negedge clk);
                rx_ready_a = 1'b0;
                checks++;
                if (obs_a() !== {1'b1, 8'h55, 4'b0000}) begin
                    errors++;
                    $display("FAIL overrun_coincide: got %h expected %h", obs_a(), {1'b1, 8'h55, 4'b0000});
                end
                @(negedge clk);
                checks++;
                if (rx_valid_a !== 1'b1) begin
                    errors++;
                    $display("FAIL overrun_coincide_hold: got valid=%b expected 1", rx_valid_a);
                end
            end
        join
        rx_ready_a = 1'b1;
        @(negedge clk);
        rx_ready_a = 1'b0;
    endtask

    task automatic test_break();
        int         nvalid;
        logic [12:0] cap;
        rx_ready_a = 1'b1;
        data_tx_a  = 1'b0;
        nvalid     = 0;
        cap        = '0;
        for (int i = 0; i < 192; i++) begin
            @(negedge clk);
            if (rx_valid_a) begin
                nvalid++;
                cap = obs_a();
            end
        end
        checks++;
        if (nvalid !== 1) begin
            errors++;
            $display("FAIL break_count: got %0d words expected 1", nvalid);
        end
        checks++;
        if (cap !== {1'b1, 8'h00, 4'b0110}) begin
            errors++;
            $display("FAIL break_word: got %h expected %h", cap, {1'b1, 8'h00, 4'b0110});
        end
        checks++;
        if (active_flag_a !== 1'b1) begin
            errors++;
            $display("FAIL break_wait: got active=%b expected 1", active_flag_a);
        end
        data_tx_a = 1'b1;
        nvalid    = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (rx_valid_a) nvalid++;
        end
        checks++;
        if ({nvalid != 0, active_flag_a} !== 2'b00) begin
            errors++;
            $display("FAIL break_release: got words=%0d active=%b expected 0 0", nvalid, active_flag_a);
        end
        rx_ready_a = 1'b0;
        send_a(frm_a(8'h5A, 1'b0, 1'b1), -1, 1000);
        checks++;
        if (obs_a() !== {1'b1, 8'h5A, 4'b0000}) begin
            errors++;
            $display("FAIL break_resume: got %h expected %h", obs_a(), {1'b1, 8'h5A, 4'b0000});
        end
        rx_ready_a = 1'b1;
        @(negedge clk);
        rx_ready_a = 1'b0;
    endtask

    task automatic test_reset_mid();
        rx_ready_a = 1'b0;
        send_a(frm_a(8'h3C, 1'b1, 1'b1), -1, 1000);
        // Stop 88 cycles in, i.e. inside data bit 4.
        send_a(frm_a(8'h5A, 1'b0, 1'b1), -1, 88);
        checks++;
        if ({rx_valid_a, active_flag_a} !== 2'b11) begin
            errors++;
            $display("FAIL reset_mid_pre: got %b expected 11", {rx_valid_a, active_flag_a});
        end
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        checks++;
        if ({obs_a(), active_flag_a} !== 14'h0) begin
            errors++;
            $display("FAIL reset_mid_clear: got %h expected %h", {obs_a(), active_flag_a}, 14'h0);
        end
        idle(200);
        checks++;
        if (rx_valid_a !== 1'b0) begin
            errors++;
            $display("FAIL reset_mid_abort: got valid=%b expected 0", rx_valid_a);
        end
        send_a(frm_a(8'h5A, 1'b0, 1'b1), -1, 1000);
        checks++;
        if (obs_a() !== {1'b1, 8'h5A, 4'b0000}) begin
            errors++;
            $display("FAIL reset_mid_resume: got %h expected %h", obs_a(), {1'b1, 8'h5A, 4'b0000});
        end
        rx_ready_a = 1'b1;
        @(negedge clk);
        rx_ready_a = 1'b0;
    endtask

    task automatic test_param_sweep();
        int          nvalid;
        int          first;
        logic [13:0] cap;
        // 0x1A5 has five ones, so the odd-parity bit is 0.
        rx_ready_b = 1'b1;
        nvalid     = 0;
        first      = 0;
        cap        = '0;
        fork
            send_b(frm_b(9'h1A5, 1'b0));
            for (int i = 1; i <= 110; i++) begin
                @(negedge clk);
                if (rx_valid_b) begin
                    nvalid++;
                    if (nvalid == 1) begin
                        first = i;
                        cap   = obs_b();
                    end
                end
            end
        join
        checks++;
        if ({nvalid, first} !== {32'd1, 32'd105}) begin
            errors++;
            $display("FAIL sweep_timing: got words=%0d at %0d expected 1 at 105", nvalid, first);
        end
        checks++;
        if (cap !== {1'b1, 9'h1A5, 4'b0000}) begin
            errors++;
            $display("FAIL sweep_word: got %h expected %h", cap, {1'b1, 9'h1A5, 4'b0000});
        end
        rx_ready_b = 1'b0;
        idle(4);
        send_b(frm_b(9'h1A5, 1'b1));
        idle(4);
        checks++;
        if (obs_b() !== {1'b1, 9'h1A5, 4'b1000}) begin
            errors++;
            $display("FAIL sweep_odd_parity: got %h expected %h", obs_b(), {1'b1, 9'h1A5, 4'b1000});
        end
    endtask

    initial begin
        reset      = 1'b1;
        data_tx_a  = 1'b1;
        data_tx_b  = 1'b1;
        rx_ready_a = 1'b0;
        rx_ready_b = 1'b0;
        @(negedge clk);
        test_reset();
        test_clean();
        test_errors();
        test_noise();
        test_overrun();
        test_break();
        test_reset_mid();
        test_param_sweep();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/uart_rx_deserializer.md
# uart_rx_deserializer

Parametrised UART receive deserialiser, the next generation of the fixed 11-bit SIPO receiver in the APB-UART path. It oversamples the serial line, takes a 3-sample majority vote at bit centre, and deframes in hardware. Data width, parity, stop-bit count and oversampling ratio are configurable. It presents the data word with per-frame error status through a valid/ready handshake to the APB-side register/FIFO logic, and adds false-start rejection, break detection and overrun reporting.

## Interface
- `DATA_BITS`, default 8: data bits per frame, legal range 5..9, sent LSB first.
- `OVERSAMPLE`, default 16: `baud_clk` cycles per bit, even, legal range 8..32.
- `PARITY_EN`, default 1: 1 means a parity bit follows the data.
- `PARITY_ODD`, default 0: 0 selects even parity, 1 selects odd.
- `STOP_BITS`, default 1: 1 or 2.
- `baud_clk` input 1: sampling clock at OVERSAMPLE × baud rate. Single clock domain.
- `reset` input 1: synchronous, active-high reset.
- `data_tx` input 1: asynchronous serial line, idle high.
- `rx_data` output DATA_BITS: received word.
- `rx_valid` output 1: word and status are available.
- `rx_ready` input 1: consumer accepts the word.
- `parity_err` output 1: parity mismatch in the held word.
- `frame_err` output 1: a stop bit was sampled low.
- `break_det` output 1: the held word is a break condition.
- `overrun` output 1: one or more frames were dropped while `rx_valid` was held.
- `active_flag` output 1: a frame is in progress (state ≠ IDLE).

## Operation
- `data_tx` passes through a 2-flop synchroniser, reset value 1. "line" below means the synchronised value.
- `tick` is a counter of width $clog2(OVERSAMPLE). It is held at 0 in IDLE, increments each cycle otherwise, and wraps at OVERSAMPLE-1; the wrap marks the end of a bit period. MID = OVERSAMPLE/2.
- The bit value is the majority of line at tick MID-1, MID and MID+1. It resolves in the **decision cycle** (tick == MID+1).
- FSM states are IDLE, START, DATA, PARITY, STOP and BRK_WAIT.
- IDLE → START when line == 0.
- START, decision cycle:
  - majority 1 is a false start → IDLE, and no output changes;
  - otherwise, at tick wrap → DATA.
- DATA shifts one bit per period into a DATA_BITS shift register, LSB first, with `bit_cnt` counting 0..DATA_BITS-1. After the last period the FSM goes to PARITY if PARITY_EN, else STOP.
- PARITY compares the voted bit against the XOR of the data, inverted when PARITY_ODD. A mismatch latches a local parity error.
- STOP uses one period per stop bit. Any stop bit voted 0 latches a local frame error.
- The frame completes in the decision cycle of the final stop bit. The FSM then goes directly to IDLE, which allows resync on an immediately following start bit.
- A break is: all data bits 0, parity bit 0 (if enabled), and the final stop bit 0. On a break the word is delivered with `break_det`=1 and `frame_err`=1, then the FSM goes to BRK_WAIT. BRK_WAIT → IDLE only once line == 1.
- Output register update on frame completion:
  - if `rx_valid`==0, or `rx_valid`&&`rx_ready` in that same cycle: load `rx_data`, `parity_err`, `frame_err` and `break_det`; set `rx_valid`=1; `overrun`=0;
  - otherwise: drop the new frame, set `overrun`=1, and keep the held data unchanged.
- A handshake (`rx_valid`&&`rx_ready`) without a completion clears `rx_valid` and `overrun`.
- `rx_data` and all status outputs are stable while `rx_valid`=1.
- `parity_err` is always 0 when PARITY_EN=0.

## Timing
- Reset values: every output is 0, state is IDLE, `tick` and `bit_cnt` are 0, and the synchroniser flops are 1.
- Reset mid-frame aborts the frame; no `rx_valid` is produced.
- Line to FSM latency is 2 cycles through the synchroniser.
- `rx_valid` rises in the cycle after the final stop bit's decision cycle. It falls in the cycle after the handshake, unless a completion coincides with the handshake, in which case it stays high with the new word.
- `active_flag` is combinational from the state register.
- A start bit shorter than MID+2 cycles is rejected; `active_flag` returns to 0 the cycle after the START decision cycle.

## Structure
- Package `uart_pkg` holds:
  - typedef enum `uart_rx_state_t` {IDLE, START, DATA, PARITY, STOP, BRK_WAIT};
  - parity-mode constants `UART_PAR_EVEN`/`UART_PAR_ODD`;
  - the shared legal-range constants for DATA_BITS and OVERSAMPLE.
- Sub-module `uart_rx_sampler` contains the synchroniser, tick counter and majority voter. It outputs `line`, `bit_val`, `decide` (decision cycle) and `bit_end` (tick wrap).
- The top level holds the FSM, shift register, parity/frame/break checking and the output handshake register.
- Elaboration asserts reject any parameter outside its legal range.

## Test plan
All scenarios use DATA_BITS=8, OVERSAMPLE=16, PARITY_EN=1, PARITY_ODD=0 (even parity) and STOP_BITS=1 unless stated otherwise.

- **Clean frame:** send 0xA5 with parity 0 and stop 1, `rx_ready`=1 → one-cycle `rx_valid` with `rx_data`=0xA5 and all errors 0, asserted 1 cycle after the stop decision cycle.
- **Parity error:** send 0x3C with parity bit 1 → `rx_data`=0x3C, `parity_err`=1, `frame_err`=0.
- **Noise rejection:** line low for 4 cycles only → no `rx_valid`, and `active_flag` is 0 after the START decision. Separately, a 1-cycle high glitch at tick MID inside bit 3 of 0x00 → `rx_data`=0x00.
- **Overrun:** with `rx_ready`=0, send 0x11 then 0x22 → `rx_data`=0x11, `overrun`=1. Raise `rx_ready` for 1 cycle → `rx_valid`=0 and `overrun`=0. Then raise `rx_ready` in the exact completion cycle of the next frame → new word loaded and `overrun`=0.
- **Break:** hold line low for 12 bit periods → exactly one word with `rx_data`=0x00, `frame_err`=1, `break_det`=1. No further frame until line returns high, after which 0x5A is received cleanly.
- **Reset and parameter sweep:** assert `reset` during data bit 4 → all outputs 0 on the next cycle, and a following 0x5A is received correctly. Repeat the clean-frame case with DATA_BITS=9, PARITY_ODD=1, STOP_BITS=2 and OVERSAMPLE=8 using word 0x1A5 → `rx_data`=0x1A5 with no errors.
